// File: rtl/run_launcher.sv
// Launch controller for a single processor run: raises start, measures the
// run length, and reports completion, timeout or abort back to the host.
//
// Ports:
//   clk            - single clock, all state changes on its rising edge
//   rst_n          - asynchronous active-low reset
//   go             - host request to launch one run (sampled in IDLE only)
//   abort          - host request to cancel the run (sampled in RUN only)
//   finish_process - completion level from the processor (clk domain)
//   start          - registered run request level to the processor
//   busy           - registered, high whenever not IDLE
//   done           - registered one-cycle pulse on normal completion
//   timeout        - registered one-cycle pulse on timeout
//   cycle_count    - measured run length, held until the next completion
module run_launcher #(
    parameter int          CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             abort,
    input  logic             finish_process,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [CNT_W-1:0] L_TMO = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] L_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cycle_count;
    logic             r_start;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;

    state_t           w_state;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cycle_count;
    logic             w_start;
    logic             w_busy;
    logic             w_done;
    logic             w_timeout;

    // RUN-cycle events, made mutually exclusive here so the
    // priority finish > abort > timeout lives in one place.
    logic             w_ev_fin;
    logic             w_ev_abort;
    logic             w_ev_tmo;
    logic             w_ev_none;

    assign w_cnt_inc = r_cnt + L_ONE;

    always_comb begin
        w_ev_fin   = finish_process;
        w_ev_abort = !finish_process && abort;
        w_ev_tmo   = !finish_process && !abort
                     && (w_cnt_inc == L_TMO);
        w_ev_none  = !(w_ev_fin || w_ev_abort || w_ev_tmo);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_cycle_count <= '0;
            r_start       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_cycle_count <= w_cycle_count;
            r_start       <= w_start;
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_timeout     <= w_timeout;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_cycle_count = r_cycle_count;
        w_start       = r_start;
        w_busy        = r_busy;
        w_done        = 1'b0;
        w_timeout     = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                // A processor still reporting finish is not yet idle,
                // so a launch waits until it drops.
                if (go && !finish_process) begin
                    w_state = S_RUN;
                    w_cnt   = '0;
                    w_start = 1'b1;
                    w_busy  = 1'b1;
                end
            end

            S_RUN: begin
                w_cnt = w_cnt_inc;
                unique case (1'b1)
                    w_ev_fin: begin
                        w_state       = S_DRAIN;
                        w_start       = 1'b0;
                        w_cycle_count = w_cnt_inc;
                        w_done        = 1'b1;
                    end
                    w_ev_abort: begin
                        w_state = S_DRAIN;
                        w_start = 1'b0;
                    end
                    w_ev_tmo: begin
                        w_state       = S_DRAIN;
                        w_start       = 1'b0;
                        w_cycle_count = L_TMO;
                        w_timeout     = 1'b1;
                    end
                    w_ev_none: begin
                        w_state = S_RUN;
                    end
                    default: begin
                        w_state = S_RUN;
                    end
                endcase
            end

            S_DRAIN: begin
                // Wait for the processor to drop finish before
                // allowing another launch.
                if (!finish_process) begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                end
            end

            default: begin
                w_state = S_IDLE;
                w_start = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign start       = r_start;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_run_launcher.sv
// Directed bench for run_launcher with a scoreboard of expected
// completion pulses (kind and cycle_count).
module tb_run_launcher;

    logic        clk;
    logic        rst_n;
    logic        go;
    logic        abort;
    logic        finish_process;
    logic        start;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] cycle_count;

    typedef struct {
        bit          is_to;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];

    int n_cmp;
    int n_bad;
    int start_cnt;
    int done_cnt;
    int to_cnt;

    run_launcher #(
        .CNT_W(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .go(go),
        .abort(abort),
        .finish_process(finish_process),
        .start(start),
        .busy(busy),
        .done(done),
        .timeout(timeout),
        .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_to, input logic [31:0] cnt);
        exp_t e;
        e.is_to = is_to;
        e.cnt   = cnt;
        q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (start) start_cnt++;
        if (done) done_cnt++;
        if (timeout) to_cnt++;
        if (done || timeout) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {62'd0, done, timeout}, 64'd0);
            end else begin
                e = q.pop_front();
                chk("pulse_kind", {62'd0, done, timeout},
                    e.is_to ? 64'd1 : 64'd2);
                chk("pulse_count", {32'd0, cycle_count}, {32'd0, e.cnt});
            end
        end
    endtask

    task automatic clr_stats();
        start_cnt = 0;
        done_cnt  = 0;
        to_cnt    = 0;
    endtask

    initial begin
        bit ok;
        n_cmp = 0;
        n_bad = 0;
        clr_stats();
        rst_n          = 1'b0;
        go             = 1'b0;
        abort          = 1'b0;
        finish_process = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start", {63'd0, start}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_timeout", {63'd0, timeout}, 64'd0);
        chk("rst_count", {32'd0, cycle_count}, 64'd0);
        rst_n = 1'b1;
        tick();

        // normal run, finish on 5th RUN cycle, held 2 cycles
        clr_stats();
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("run1_start", {63'd0, start}, 64'd1);
        chk("run1_busy", {63'd0, busy}, 64'd1);
        repeat (4) tick();
        finish_process = 1'b1;
        push(1'b0, 32'd5);
        tick();
        chk("drain1_start", {63'd0, start}, 64'd0);
        chk("drain1_busy", {63'd0, busy}, 64'd1);
        tick();
        chk("drain1_done_width", {63'd0, done}, 64'd0);
        chk("drain1_hold_busy", {63'd0, busy}, 64'd1);
        finish_process = 1'b0;
        tick();
        chk("run1_idle_busy", {63'd0, busy}, 64'd0);
        chk("run1_start_cycles", 64'(start_cnt), 64'd5);
        chk("run1_done_pulses", 64'(done_cnt), 64'd1);
        chk("run1_count_hold", {32'd0, cycle_count}, 64'd5);

        // timeout with finish held low
        clr_stats();
        push(1'b1, 32'd8);
        go = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 0) go = 1'b0;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("to_bound", {63'd0, ok}, 64'd1);
        chk("to_start_cycles", 64'(start_cnt), 64'd8);
        chk("to_pulses", 64'(to_cnt), 64'd1);
        chk("to_no_done", 64'(done_cnt), 64'd0);
        chk("to_count", {32'd0, cycle_count}, 64'd8);

        // finish on the 8th RUN cycle beats timeout
        clr_stats();
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (7) tick();
        finish_process = 1'b1;
        push(1'b0, 32'd8);
        tick();
        finish_process = 1'b0;
        tick();
        chk("fin8_no_timeout", 64'(to_cnt), 64'd0);
        chk("fin8_done", 64'(done_cnt), 64'd1);
        chk("fin8_idle", {63'd0, busy}, 64'd0);

        // go while processor still finishing
        clr_stats();
        finish_process = 1'b1;
        go = 1'b1;
        repeat (2) tick();
        chk("gofin_start", {63'd0, start}, 64'd0);
        chk("gofin_busy", {63'd0, busy}, 64'd0);
        finish_process = 1'b0;
        tick();
        go = 1'b0;
        chk("gofin_launch", {63'd0, start}, 64'd1);
        repeat (4) tick();
        finish_process = 1'b1;
        push(1'b0, 32'd5);
        tick();
        finish_process = 1'b0;
        tick();
        chk("gofin_count", {32'd0, cycle_count}, 64'd5);

        // abort on 3rd RUN cycle keeps previous count
        clr_stats();
        abort = 1'b1;
        tick();
        chk("abort_idle_ignored", {63'd0, busy}, 64'd0);
        abort = 1'b0;
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_start", {63'd0, start}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd1);
        tick();
        chk("abort_idle", {63'd0, busy}, 64'd0);
        chk("abort_no_pulse", 64'(done_cnt + to_cnt), 64'd0);
        chk("abort_count", {32'd0, cycle_count}, 64'd5);

        // finish and abort together: finish wins
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        finish_process = 1'b1;
        abort = 1'b1;
        push(1'b0, 32'd2);
        tick();
        finish_process = 1'b0;
        abort = 1'b0;
        tick();

        // abort on 8th RUN cycle beats timeout
        clr_stats();
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (7) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        chk("abort8_no_pulse", 64'(done_cnt + to_cnt), 64'd0);
        chk("abort8_count", {32'd0, cycle_count}, 64'd2);

        // asynchronous reset on 4th RUN cycle
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_start", {63'd0, start}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_count", {32'd0, cycle_count}, 64'd0);
        chk("arst_pulses", {62'd0, done, timeout}, 64'd0);
        #1;
        rst_n = 1'b1;
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("post_rst_start", {63'd0, start}, 64'd1);
        repeat (3) tick();
        finish_process = 1'b1;
        push(1'b0, 32'd4);
        tick();
        finish_process = 1'b0;
        tick();
        chk("post_rst_count", {32'd0, cycle_count}, 64'd4);
        chk("post_rst_idle", {63'd0, busy}, 64'd0);

        chk("sb_empty", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/run_launcher.md
RUN_LAUNCHER -- requirements
Module: run_launcher

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of the cycle counter.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, giving the maximum number of RUN cycles; legal range is 1 to 2^CNT_W-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port go, input, 1 bit: host request to launch one processor run.
REQ-006 The block SHALL have port abort, input, 1 bit: host request to cancel the run in progress.
REQ-007 The block SHALL have port finish_process, input, 1 bit: completion level from the processor, in the clk domain with no synchronizer.
REQ-008 The block SHALL have port start, output, 1 bit: run request level driven to the processor.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the block is not in IDLE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse on normal completion.
REQ-011 The block SHALL have port timeout, output, 1 bit: one-cycle pulse on timeout.
REQ-012 The block SHALL have port cycle_count, output, CNT_W bits: measured run length, held until the next completion.

Function
REQ-013 The block SHALL implement a registered FSM with exactly three states: IDLE, RUN and DRAIN; start, busy, done and timeout SHALL all be registered.
REQ-014 IDLE behaviour: start=0, busy=0.
- IDLE SHALL move to RUN when go=1 and finish_process=0, clearing the internal counter to 0.
- When go=1 and finish_process=1, the block SHALL stay in IDLE (processor not yet idle), with no outputs changed.
REQ-015 RUN behaviour: start=1, busy=1; the internal counter SHALL increment by 1 each RUN cycle.
REQ-016 Completion in RUN: if finish_process=1, the block SHALL go to DRAIN, load cycle_count with counter+1 (finish seen on the first RUN cycle gives 1), and assert done in the first DRAIN cycle only.
REQ-017 Timeout in RUN: if finish_process=0, abort=0 and counter+1 == TIMEOUT_CYCLES, the block SHALL go to DRAIN, load cycle_count with TIMEOUT_CYCLES, and assert timeout in the first DRAIN cycle only.
REQ-018 Abort in RUN: if abort=1 and finish_process=0, the block SHALL go to DRAIN with no done or timeout pulse, leaving cycle_count unchanged.
REQ-019 Simultaneous events in the same RUN cycle SHALL resolve with priority finish_process > abort > timeout; done and timeout SHALL never be asserted together.
REQ-020 DRAIN behaviour: start=0, busy=1; the block SHALL return to IDLE on the first cycle finish_process=0 and stay in DRAIN while finish_process=1, with no timeout in DRAIN.
REQ-021 The earliest new launch SHALL be the cycle after DRAIN returns to IDLE; go SHALL be ignored in RUN and DRAIN, and abort SHALL be ignored outside RUN.
REQ-022 The counter SHALL never exceed TIMEOUT_CYCLES, so no overflow handling is required; arithmetic is unsigned CNT_W bits.
REQ-023 The start-to-count latency SHALL be as follows: start rises on the clock edge that enters RUN, and cycle_count and done update on the same edge that enters DRAIN.

Reset
REQ-024 While rst_n=0, the block SHALL immediately (asynchronously) force state=IDLE, start=0, busy=0, done=0, timeout=0, cycle_count=0 and counter=0.
REQ-025 Reset asserted mid-RUN or mid-DRAIN SHALL abandon the run with no done or timeout pulse; after release the block SHALL accept go from the first clock edge with rst_n=1.

Verification
REQ-026 Reset, then go=1 for 1 cycle, with finish_process raised on the 5th RUN cycle and lowered 2 cycles later -> start high for 5 cycles, done pulse of 1 cycle, cycle_count=5, busy low after DRAIN.
REQ-027 With TIMEOUT_CYCLES=8 and finish_process held 0 -> start high for exactly 8 cycles, timeout pulse, cycle_count=8, done never high.
REQ-028 With TIMEOUT_CYCLES=8 and finish_process=1 on the 8th RUN cycle -> done=1, timeout=0, cycle_count=8.
REQ-029 go=1 while finish_process=1 in IDLE -> no start, busy stays 0; after finish_process falls, go launches normally.
REQ-030 abort=1 on the 3rd RUN cycle after a prior run with cycle_count=5 -> start drops, no pulses, cycle_count stays 5.
REQ-031 rst_n pulled low on the 4th RUN cycle -> start=0 asynchronously, before the next clock edge; all outputs are 0; a go after release yields a correct new run.
